// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA position counters with sync, blank and line/frame pulses.
// Every output is registered from the next counter values so it lines up with DrawX/DrawY.
module vga_timing_gen #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33
) (
    input  logic       vga_clk,
    input  logic       reset,
    input  logic       pix_en,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       frame_start,
    output logic       line_start
);
    localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0]  H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
    // 11-bit bounds so a sync end of exactly 1024 does not wrap to 0
    localparam logic [10:0] H_VIS   = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS   = 11'(V_VISIBLE);
    localparam logic [10:0] HS_BEG  = 11'(H_VISIBLE + H_FP);
    localparam logic [10:0] HS_END  = 11'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [10:0] VS_BEG  = 11'(V_VISIBLE + V_FP);
    localparam logic [10:0] VS_END  = 11'(V_VISIBLE + V_FP + V_SYNC);

    logic [9:0]  r_hc, r_vc;
    logic        r_hs, r_vs, r_blank, r_frame_start, r_line_start;
    logic [9:0]  w_hc_nxt, w_vc_nxt;
    logic [10:0] w_hx, w_vx;
    logic        w_h_wrap, w_hs_nxt, w_vs_nxt, w_blank_nxt;

    always_comb begin
        // >= keeps any out-of-range count from escaping the legal range
        w_h_wrap    = r_hc >= H_LAST;
        w_hc_nxt    = w_h_wrap ? 10'd0 : r_hc + 10'd1;
        w_vc_nxt    = !w_h_wrap ? r_vc : (r_vc >= V_LAST) ? 10'd0 : r_vc + 10'd1;
        w_hx        = {1'b0, w_hc_nxt};
        w_vx        = {1'b0, w_vc_nxt};
        w_hs_nxt    = !(w_hx >= HS_BEG && w_hx < HS_END);
        w_vs_nxt    = !(w_vx >= VS_BEG && w_vx < VS_END);
        w_blank_nxt = (w_hx < H_VIS) && (w_vx < V_VIS);
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            r_hc          <= H_LAST;
            r_vc          <= V_LAST;
            r_hs          <= 1'b1;
            r_vs          <= 1'b1;
            r_blank       <= 1'b0;
            r_frame_start <= 1'b0;
            r_line_start  <= 1'b0;
        end else if (pix_en) begin
            r_hc          <= w_hc_nxt;
            r_vc          <= w_vc_nxt;
            r_hs          <= w_hs_nxt;
            r_vs          <= w_vs_nxt;
            r_blank       <= w_blank_nxt;
            r_frame_start <= (w_hc_nxt == 10'd0) && (w_vc_nxt == 10'd0);
            r_line_start  <= w_hc_nxt == 10'd0;
        end
    end

    assign DrawX       = r_hc;
    assign DrawY       = r_vc;
    assign hs          = r_hs;
    assign vs          = r_vs;
    assign blank       = r_blank;
    assign frame_start = r_frame_start;
    assign line_start  = r_line_start;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks on a default 640x480 instance and a tiny 16x11 instance.
// The tiny instance (H 8/2/3/3, V 6/1/2/2) makes whole-frame behaviour reachable in few cycles.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic pix_en = 1'b0;

    logic       d_hs, d_vs, d_bl, d_fs, d_ls;
    logic [9:0] d_x, d_y;
    logic       s_hs, s_vs, s_bl, s_fs, s_ls;
    logic [9:0] s_x, s_y;

    int n_cmp = 0;
    int n_err = 0;
    bit mon_s = 1'b0;
    bit mon_d = 1'b0;
    int n_clk, n_fs, n_ls, n_bl, n_hs, n_vs, n_dhs, n_fall, n_bad;
    logic d_hs_prev = 1'b1;

    vga_timing_gen u_def (
        .vga_clk(clk), .reset(rst), .pix_en(pix_en),
        .hs(d_hs), .vs(d_vs), .blank(d_bl), .DrawX(d_x), .DrawY(d_y),
        .frame_start(d_fs), .line_start(d_ls)
    );

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(2)
    ) u_sml (
        .vga_clk(clk), .reset(rst), .pix_en(pix_en),
        .hs(s_hs), .vs(s_vs), .blank(s_bl), .DrawX(s_x), .DrawY(s_y),
        .frame_start(s_fs), .line_start(s_ls)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mon_s) begin
            n_clk++;
            if (s_fs) n_fs++;
            if (s_ls) n_ls++;
            if (s_bl) n_bl++;
            if (!s_hs) n_hs++;
            if (!s_vs) n_vs++;
        end
        if (mon_d) begin
            if (!d_hs) n_dhs++;
            if (!d_hs && d_hs_prev) begin
                n_fall++;
                if (d_x != 10'd656) n_bad++;
            end
        end
        d_hs_prev = d_hs;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk10(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [49:0] obs, input logic [49:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [49:0] snap();
        return {d_x, d_y, d_hs, d_vs, d_bl, d_fs, d_ls, s_x, s_y, s_hs, s_vs, s_bl, s_fs, s_ls};
    endfunction

    task automatic chk_rst(input string tag);
        chk10({tag, "_dx"}, d_x, 10'd799);
        chk10({tag, "_dy"}, d_y, 10'd524);
        chk1({tag, "_dhs"}, d_hs, 1'b1);
        chk1({tag, "_dvs"}, d_vs, 1'b1);
        chk1({tag, "_dbl"}, d_bl, 1'b0);
        chk1({tag, "_dfs"}, d_fs, 1'b0);
        chk1({tag, "_dls"}, d_ls, 1'b0);
        chk10({tag, "_sx"}, s_x, 10'd15);
        chk10({tag, "_sy"}, s_y, 10'd10);
        chk1({tag, "_sfs"}, s_fs, 1'b0);
    endtask

    task automatic chk_first(input string tag);
        chk10({tag, "_dx"}, d_x, 10'd0);
        chk10({tag, "_dy"}, d_y, 10'd0);
        chk1({tag, "_dbl"}, d_bl, 1'b1);
        chk1({tag, "_dfs"}, d_fs, 1'b1);
        chk1({tag, "_dls"}, d_ls, 1'b1);
        chk10({tag, "_sx"}, s_x, 10'd0);
        chk10({tag, "_sy"}, s_y, 10'd0);
        chk1({tag, "_sfs"}, s_fs, 1'b1);
    endtask

    task automatic goto_s(input logic [9:0] x, input logic [9:0] y);
        int k = 0;
        while (!(s_x == x && s_y == y) && k < 400) begin
            step();
            k++;
        end
        chk1("reach_s", s_x == x && s_y == y, 1'b1);
    endtask

    task automatic goto_d(input logic [9:0] x, input logic [9:0] y);
        int k = 0;
        while (!(d_x == x && d_y == y) && k < 2000) begin
            step();
            k++;
        end
        chk1("reach_d", d_x == x && d_y == y, 1'b1);
    endtask

    initial begin
        logic [49:0] w;
        logic [9:0]  px;
        logic        fs_prev, rise;
        int          k, hi;

        // reset applied with no clock edge yet
        #1 rst = 1'b1;
        #1 chk_rst("rst_async");
        pix_en = 1'b1;
        step();
        step();
        chk_rst("rst_held");
        rst = 1'b0;
        step();
        chk_first("first");
        step();
        chk10("second_dx", d_x, 10'd1);
        chk10("second_dy", d_y, 10'd0);
        chk1("second_dfs", d_fs, 1'b0);
        chk1("second_dls", d_ls, 1'b0);
        chk1("second_dbl", d_bl, 1'b1);

        // default horizontal sync edges and line wrap
        goto_d(10'd655, 10'd0);
        chk1("d_hs_655", d_hs, 1'b1);
        step();
        chk1("d_hs_656", d_hs, 1'b0);
        chk1("d_bl_656", d_bl, 1'b0);
        goto_d(10'd751, 10'd0);
        chk1("d_hs_751", d_hs, 1'b0);
        step();
        chk1("d_hs_752", d_hs, 1'b1);
        goto_d(10'd799, 10'd0);
        chk1("d_ls_799", d_ls, 1'b0);
        step();
        chk10("d_wrap_x", d_x, 10'd0);
        chk10("d_wrap_y", d_y, 10'd1);
        chk1("d_wrap_ls", d_ls, 1'b1);
        chk1("d_wrap_fs", d_fs, 1'b0);

        // one complete small frame, frame_start to frame_start
        goto_s(10'd0, 10'd0);
        chk1("s_fs_at_00", s_fs, 1'b1);
        {n_clk, n_fs, n_ls, n_bl, n_hs, n_vs} = '0;
        mon_s = 1'b1;
        step();
        k = 1;
        while (!s_fs && k < 400) begin
            step();
            k++;
        end
        mon_s = 1'b0;
        chki("frame_period", k, 176);
        chki("frame_clocks", n_clk, 176);
        chki("frame_fs_cnt", n_fs, 1);
        chki("frame_ls_cnt", n_ls, 11);
        chki("frame_blank", n_bl, 48);
        chki("frame_hs_low", n_hs, 33);
        chki("frame_vs_low", n_vs, 32);

        // default sync over three whole lines
        goto_d(10'd0, 10'd2);
        {n_dhs, n_fall, n_bad} = '0;
        mon_d = 1'b1;
        repeat (2400) step();
        mon_d = 1'b0;
        chki("d_hs_low_3l", n_dhs, 288);
        chki("d_hs_falls", n_fall, 3);
        chki("d_hs_fall_pos", n_bad, 0);
        chk1("d_vs_line5", d_vs, 1'b1);

        // small-instance corners
        goto_s(10'd15, 10'd0);
        step();
        chk10("s_c1_x", s_x, 10'd0);
        chk10("s_c1_y", s_y, 10'd1);
        chk1("s_c1_ls", s_ls, 1'b1);
        chk1("s_c1_fs", s_fs, 1'b0);
        goto_s(10'd9, 10'd2);
        chk1("s_hs_9", s_hs, 1'b1);
        step();
        chk1("s_hs_10", s_hs, 1'b0);
        goto_s(10'd12, 10'd2);
        chk1("s_hs_12", s_hs, 1'b0);
        step();
        chk1("s_hs_13", s_hs, 1'b1);
        goto_s(10'd7, 10'd5);
        chk1("s_bl_7_5", s_bl, 1'b1);
        step();
        chk10("s_c2_x", s_x, 10'd8);
        chk1("s_bl_8_5", s_bl, 1'b0);
        goto_s(10'd15, 10'd6);
        chk1("s_vs_6", s_vs, 1'b1);
        chk1("s_bl_15_6", s_bl, 1'b0);
        step();
        chk10("s_c3_y", s_y, 10'd7);
        chk1("s_vs_7", s_vs, 1'b0);
        goto_s(10'd15, 10'd8);
        chk1("s_vs_8", s_vs, 1'b0);
        step();
        chk1("s_vs_9", s_vs, 1'b1);
        goto_s(10'd15, 10'd10);
        chk1("s_fs_pre", s_fs, 1'b0);
        step();
        chk10("s_c4_x", s_x, 10'd0);
        chk10("s_c4_y", s_y, 10'd0);
        chk1("s_c4_fs", s_fs, 1'b1);
        chk1("s_c4_ls", s_ls, 1'b1);
        chk1("s_c4_bl", s_bl, 1'b1);

        // disabled edges hold everything, enabled edges advance
        repeat (3) begin
            pix_en = 1'b0;
            w = snap();
            px = d_x;
            step();
            chkw("hold", snap(), w);
            pix_en = 1'b1;
            step();
            chk10("advance", d_x, (px == 10'd799) ? 10'd0 : px + 10'd1);
        end

        // alternating enable doubles the frame period and stretches frame_start
        fs_prev = s_fs;
        k = 0;
        rise = 1'b0;
        while (!rise && k < 1000) begin
            pix_en = ~pix_en;
            step();
            k++;
            rise = s_fs && !fs_prev;
            fs_prev = s_fs;
        end
        chk1("half_rate_rise", rise, 1'b1);
        k = 0;
        hi = 0;
        rise = 1'b0;
        while (!rise && k < 1000) begin
            pix_en = ~pix_en;
            step();
            k++;
            if (s_fs) hi++;
            rise = s_fs && !fs_prev;
            fs_prev = s_fs;
        end
        chki("half_rate_period", k, 352);
        chki("half_rate_fs_hi", hi, 2);
        pix_en = 1'b1;

        // asynchronous reset in mid-frame, then clean restart
        goto_s(10'd5, 10'd4);
        #2 rst = 1'b1;
        #1 chk_rst("rst_mid");
        step();
        chk_rst("rst_mid_held");
        rst = 1'b0;
        step();
        chk_first("restart");
        step();
        chk10("restart2_sx", s_x, 10'd1);
        chk1("restart2_sfs", s_fs, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
